float32_mult_round: RTL and testbench

FLOAT32_MULT_ROUND -- requirements
Module: float32_mult_round

---
 rtl/float32_mult_round_pkg.sv | 11 +
 rtl/float32_round_rne.sv | 29 ++
 rtl/float32_mult_round.sv | 132 +++++++++++++
 tb/tb_float32_mult_round.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/float32_mult_round_pkg.sv
// Shared binary32 constants and the signed exponent type for the multiplier back end.
package float32_mult_round_pkg;

  // Signed two's complement exponent wide enough for expA+expB-127 plus two carries.
  typedef logic signed [9:0] exp_t;

  localparam exp_t        BIAS    = exp_t'(127);
  localparam exp_t        EXP_MAX = exp_t'(255);
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

endpackage

// File: rtl/float32_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction; a carry out bumps the exponent.
module float32_round_rne
  import float32_mult_round_pkg::*;
(
  input  logic [22:0] frac_in,
  input  logic        guard,
  input  logic        sticky,
  input  exp_t        exp_in,
  output logic [22:0] frac_out,
  output exp_t        exp_out
);

  logic        inc;
  logic [23:0] sum;

  // Increment on guard when above half-way or on an exact tie with an odd LSB.
  always_comb begin
    inc = guard & (sticky | frac_in[0]);
    sum = {1'b0, frac_in} + {23'd0, inc};
    if (sum[23]) begin
      frac_out = '0;
      exp_out  = exp_in + exp_t'(1);
    end else begin
      frac_out = sum[22:0];
      exp_out  = exp_in;
    end
  end

endmodule

// File: rtl/float32_mult_round.sv
// Two-stage normalize/round/pack back end of a binary32 multiplier.
module float32_mult_round
  import float32_mult_round_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        sign_in,
  input  logic [9:0]  exp_sum_in,
  input  logic [47:0] mant_prod_in,
  input  logic        zero_in,
  input  logic        inf_in,
  input  logic        nan_in,
  output logic        valid_out,
  output logic [31:0] out_data,
  output logic        overflow,
  output logic        underflow
);

  // Stage 1 registers
  logic        s1_valid;
  logic        s1_sign;
  logic [22:0] s1_frac;
  logic        s1_guard;
  logic        s1_sticky;
  exp_t        s1_exp;
  logic        s1_zero;
  logic        s1_inf;
  logic        s1_nan;

  // Stage 1 next values
  logic [22:0] n_frac;
  logic        n_guard;
  logic        n_sticky;
  exp_t        n_exp;

  // Stage 2 next values
  logic [22:0] r_frac;
  exp_t        r_exp;
  logic [31:0] n_data;
  logic        n_ovf;
  logic        n_udf;

  // Normalize: select fraction window by the product's top bit.
  always_comb begin
    if (mant_prod_in[47]) begin
      n_frac   = mant_prod_in[46:24];
      n_guard  = mant_prod_in[23];
      n_sticky = |mant_prod_in[22:0];
      n_exp    = exp_t'(exp_sum_in) + exp_t'(1);
    end else begin
      n_frac   = mant_prod_in[45:23];
      n_guard  = mant_prod_in[22];
      n_sticky = |mant_prod_in[21:0];
      n_exp    = exp_t'(exp_sum_in);
    end
  end

  // Stage 1 register: valid every cycle, payload only on valid_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_frac   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_exp    <= '0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_nan    <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_sign   <= sign_in;
        s1_frac   <= n_frac;
        s1_guard  <= n_guard;
        s1_sticky <= n_sticky;
        s1_exp    <= n_exp;
        s1_zero   <= zero_in;
        s1_inf    <= inf_in;
        s1_nan    <= nan_in;
      end
    end
  end

  float32_round_rne u_round (
    .frac_in  (s1_frac),
    .guard    (s1_guard),
    .sticky   (s1_sticky),
    .exp_in   (s1_exp),
    .frac_out (r_frac),
    .exp_out  (r_exp)
  );

  // Pack: specials first, then overflow/underflow from the rounded exponent.
  always_comb begin
    n_data = {s1_sign, r_exp[7:0], r_frac};
    n_ovf  = 1'b0;
    n_udf  = 1'b0;
    if (s1_nan || (s1_inf && s1_zero)) begin
      n_data = QNAN;
    end else if (s1_inf) begin
      n_data = {s1_sign, 8'hFF, 23'h0};
    end else if (s1_zero) begin
      n_data = {s1_sign, 31'h0};
    end else if (r_exp >= EXP_MAX) begin
      n_data = {s1_sign, 8'hFF, 23'h0};
      n_ovf  = 1'b1;
    end else if (r_exp <= exp_t'(0)) begin
      n_data = {s1_sign, 31'h0};
      n_udf  = 1'b1;
    end
  end

  // Stage 2 register: outputs hold while no valid result arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        out_data  <= n_data;
        overflow  <= n_ovf;
        underflow <= n_udf;
      end
    end
  end

endmodule

// File: tb/tb_float32_mult_round.sv
// Directed self-checking bench for float32_mult_round.
module tb_float32_mult_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        sign_in = 1'b0;
  logic [9:0]  exp_sum_in = '0;
  logic [47:0] mant_prod_in = '0;
  logic        zero_in = 1'b0;
  logic        inf_in = 1'b0;
  logic        nan_in = 1'b0;
  logic        valid_out;
  logic [31:0] out_data;
  logic        overflow;
  logic        underflow;

  int n_cmp = 0;
  int n_bad = 0;

  float32_mult_round dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .sign_in      (sign_in),
    .exp_sum_in   (exp_sum_in),
    .mant_prod_in (mant_prod_in),
    .zero_in      (zero_in),
    .inf_in       (inf_in),
    .nan_in       (nan_in),
    .valid_out    (valid_out),
    .out_data     (out_data),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] p,
                      input logic z, input logic i, input logic n);
    valid_in     = 1'b1;
    sign_in      = s;
    exp_sum_in   = e;
    mant_prod_in = p;
    zero_in      = z;
    inf_in       = i;
    nan_in       = n;
  endtask

  task automatic idle();
    valid_in     = 1'b0;
    sign_in      = 1'b1;
    exp_sum_in   = 10'h3FF;
    mant_prod_in = '1;
    zero_in      = 1'b1;
    inf_in       = 1'b1;
    nan_in       = 1'b1;
  endtask

  // Single transaction: one edge later nothing, two edges later the result, then it holds.
  task automatic run_one(input string tag, input logic s, input logic [9:0] e, input logic [47:0] p,
                         input logic z, input logic i, input logic n,
                         input logic [31:0] xd, input logic xo, input logic xu);
    send(s, e, p, z, i, n);
    @(negedge clk);
    idle();
    chk({tag, "_lat1"}, {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    chk({tag, "_vld"},  {31'd0, valid_out}, 32'd1);
    chk({tag, "_data"}, out_data, xd);
    chk({tag, "_ovf"},  {31'd0, overflow},  {31'd0, xo});
    chk({tag, "_udf"},  {31'd0, underflow}, {31'd0, xu});
    @(negedge clk);
    chk({tag, "_drop"}, {31'd0, valid_out}, 32'd0);
    chk({tag, "_hold"}, out_data, xd);
  endtask

  logic        bs [5];
  logic [9:0]  be [5];
  logic [47:0] bp [5];
  logic [31:0] bd [5];
  logic        bo [5];
  logic        bu [5];

  initial begin
    idle();
    repeat (2) @(negedge clk);
    chk("rst_vld",  {31'd0, valid_out}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf",  {31'd0, overflow},  32'd0);
    chk("rst_udf",  {31'd0, underflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_one("one",     1'b0, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    run_one("onep5",   1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 1'b0, 1'b0);
    run_one("tie_ev",  1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    run_one("tie_od",  1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 1'b0, 1'b0);
    run_one("above",   1'b0, 10'd127, 48'h4000_0040_0001, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 1'b0, 1'b0);
    run_one("carry",   1'b0, 10'd127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    run_one("ovf",     1'b0, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    run_one("udf",     1'b1, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("nan",     1'b1, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h7FC0_0000, 1'b0, 1'b0);
    run_one("inf0",    1'b0, 10'd127, 48'h4000_0000_0000, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0);
    run_one("inf",     1'b1, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 1'b0, 1'b0);
    run_one("zero",    1'b1, 10'd254, 48'h8000_0000_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0);

    // Back-to-back stream of the main vectors
    bs[0] = 1'b0; be[0] = 10'd127; bp[0] = 48'h4000_0000_0000; bd[0] = 32'h3F80_0000; bo[0] = 1'b0; bu[0] = 1'b0;
    bs[1] = 1'b0; be[1] = 10'd127; bp[1] = 48'h9000_0000_0000; bd[1] = 32'h4010_0000; bo[1] = 1'b0; bu[1] = 1'b0;
    bs[2] = 1'b0; be[2] = 10'd127; bp[2] = 48'h4000_00C0_0000; bd[2] = 32'h3F80_0002; bo[2] = 1'b0; bu[2] = 1'b0;
    bs[3] = 1'b0; be[3] = 10'd254; bp[3] = 48'h8000_0000_0000; bd[3] = 32'h7F80_0000; bo[3] = 1'b1; bu[3] = 1'b0;
    bs[4] = 1'b1; be[4] = 10'd0;   bp[4] = 48'h4000_0000_0000; bd[4] = 32'h8000_0000; bo[4] = 1'b0; bu[4] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) send(bs[k], be[k], bp[k], 1'b0, 1'b0, 1'b0);
      else       idle();
      @(negedge clk);
      if (k >= 1) begin
        chk($sformatf("b2b%0d_vld", k - 1),  {31'd0, valid_out}, 32'd1);
        chk($sformatf("b2b%0d_data", k - 1), out_data, bd[k - 1]);
        chk($sformatf("b2b%0d_ovf", k - 1),  {31'd0, overflow},  {31'd0, bo[k - 1]});
        chk($sformatf("b2b%0d_udf", k - 1),  {31'd0, underflow}, {31'd0, bu[k - 1]});
      end
    end
    @(negedge clk);
    chk("b2b_end_vld", {31'd0, valid_out}, 32'd0);

    // Reset pulse right after a transaction is captured
    send(1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_vld",  {31'd0, valid_out}, 32'd0);
    chk("midrst_data", out_data, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d_vld", c),  {31'd0, valid_out}, 32'd0);
      chk($sformatf("postrst%0d_data", c), out_data, 32'd0);
    end

    // First transaction after reset keeps normal latency
    run_one("after", 1'b1, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hC010_0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
